// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard decoder: scancode-set-2
// prefix bytes, non-key bytes and the prefix state machine encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_E0         = 8'hE0;
    localparam logic [7:0] PS2_F0         = 8'hF0;
    localparam logic [7:0] PS2_E1         = 8'hE1;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

    localparam logic [7:0] PS2_BAT  = 8'hAA;
    localparam logic [7:0] PS2_ACK  = 8'hFA;
    localparam logic [7:0] PS2_ECHO = 8'hEE;

    // Bytes that follow the E1 of the pause sequence before the event fires.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    localparam logic [3:0] PS2_PARITY_BIT = 4'd9;
    localparam logic [3:0] PS2_STOP_BIT   = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0,
        ST_SKIP_E1
    } prefix_state_t;

    function automatic logic is_non_key(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the PS/2 lines, detects falling clock
// edges and deserialises 11-bit frames with parity, stop and timeout checks.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT     = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par_acc;
    logic [TW-1:0]          r_tmo_cnt;
    logic [7:0]             r_rx_byte;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    logic w_clk_s;
    logic w_data_s;
    logic w_fall;
    logic w_tmo;
    logic w_edge;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;
    assign w_tmo    = (r_bit_cnt != 4'd0) && (r_tmo_cnt == TW'(TIMEOUT));
    // The timeout terminal count takes priority over a coincident edge.
    assign w_edge   = w_fall & ~w_tmo;

    // NOTE: synchroniser flops reset to 1 (line idle) so release of reset
    // cannot fabricate a falling edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_par_acc   <= 1'b0;
            r_rx_byte   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_tmo) begin
                r_bit_cnt   <= 4'd0;
                r_frame_err <= 1'b1;
            end else if (w_edge) begin
                if (r_bit_cnt == 4'd0) begin
                    // A high start bit is noise: stay waiting for a real start.
                    if (!w_data_s) begin
                        r_bit_cnt <= 4'd1;
                        r_par_acc <= 1'b0;
                    end
                end else if (r_bit_cnt < PS2_PARITY_BIT) begin
                    r_shift   <= {w_data_s, r_shift[7:1]};
                    r_par_acc <= r_par_acc ^ w_data_s;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == PS2_PARITY_BIT) begin
                    r_par_acc <= r_par_acc ^ w_data_s;
                    r_bit_cnt <= PS2_STOP_BIT;
                end else begin
                    r_bit_cnt <= 4'd0;
                    if (r_par_acc && w_data_s) begin
                        r_rx_byte  <= r_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    // Saturating inter-edge counter, only live while a frame is in progress.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_edge) begin
            r_tmo_cnt <= '0;
        end else if ((r_bit_cnt != 4'd0) && (r_tmo_cnt != TW'(TIMEOUT))) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    assign rx_byte   = r_rx_byte;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder: frame receiver plus scancode-set-2 prefix state
// machine producing one-cycle key events with make/break and extended flags.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT     = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic       key_extended
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_frame_err;

    ps2_rx_frame #(
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_frame (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (w_rx_byte),
        .rx_valid  (w_rx_valid),
        .frame_err (w_frame_err)
    );

    prefix_state_t r_state;
    prefix_state_t w_state_nxt;
    logic [2:0]    r_skip;
    logic [2:0]    w_skip_nxt;
    logic          r_key_strobe;
    logic [7:0]    r_key_code;
    logic          r_key_pressed;
    logic          r_key_extended;

    logic          w_emit;
    logic [7:0]    w_code;
    logic          w_pressed;
    logic          w_ext;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_skip         <= 3'd0;
            r_key_strobe   <= 1'b0;
            r_key_code     <= 8'd0;
            r_key_pressed  <= 1'b0;
            r_key_extended <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_skip       <= w_skip_nxt;
            r_key_strobe <= w_emit;
            if (w_emit) begin
                r_key_code     <= w_code;
                r_key_pressed  <= w_pressed;
                r_key_extended <= w_ext;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_emit      = 1'b0;
        w_code      = w_rx_byte;
        w_pressed   = 1'b1;
        w_ext       = 1'b0;

        if (w_frame_err) begin
            w_state_nxt = ST_IDLE;
            w_skip_nxt  = 3'd0;
        end else if (w_rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rx_byte == PS2_E0) begin
                        w_state_nxt = ST_GOT_E0;
                    end else if (w_rx_byte == PS2_F0) begin
                        w_state_nxt = ST_GOT_F0;
                    end else if (w_rx_byte == PS2_E1) begin
                        w_state_nxt = ST_SKIP_E1;
                        w_skip_nxt  = PS2_PAUSE_SKIP;
                    end else if (!is_non_key(w_rx_byte)) begin
                        w_emit = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    if (w_rx_byte == PS2_F0) begin
                        w_state_nxt = ST_GOT_E0F0;
                    end else if (w_rx_byte != PS2_E0) begin
                        w_emit      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_GOT_F0: begin
                    w_emit      = 1'b1;
                    w_pressed   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                ST_GOT_E0F0: begin
                    w_emit      = 1'b1;
                    w_pressed   = 1'b0;
                    w_ext       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_SKIP_E1: begin
                    w_skip_nxt = r_skip - 3'd1;
                    // Pause reports as a single extended make; its break half is swallowed.
                    if (r_skip == 3'd1) begin
                        w_emit      = 1'b1;
                        w_code      = PS2_PAUSE_CODE;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_skip_nxt  = 3'd0;
                end
            endcase
        end
    end

    assign rx_byte      = w_rx_byte;
    assign rx_valid     = w_rx_valid;
    assign frame_err    = w_frame_err;
    assign key_strobe   = r_key_strobe;
    assign key_code     = r_key_code;
    assign key_pressed  = r_key_pressed;
    assign key_extended = r_key_extended;

endmodule
